// File: rtl/baby_store.sv
// baby_store: 32-word main store for the Manchester Baby core.
// Serves the core's RAM port while it runs. Owns the core's run/hold control.
// Provides a word-serial load port and a word-serial dump port, used while the core is held.
module baby_store #(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_rw_en_i,
    output logic [DATA_W-1:0] cpu_data_o,
    input  logic              cpu_stop_i,
    output logic              cpu_hold_o,
    input  logic              run_i,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    input  logic              dump_start_i,
    output logic              dump_valid_o,
    output logic [DATA_W-1:0] dump_data_o,
    input  logic              dump_ready_i
);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_LOAD = 2'd1,
        S_DUMP = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [WORDS];

    logic load_xfer;
    logic cpu_wr;

    // Only LOAD accepts load words, and only RUN lets the core write.
    assign load_xfer = (state == S_LOAD) && load_valid_i;
    assign cpu_wr    = (state == S_RUN) && cpu_rw_en_i;

    // Handshake/hold outputs decode from state alone; core reads are combinational.
    assign load_ready_o = (state == S_LOAD);
    assign cpu_hold_o   = (state != S_RUN);
    assign cpu_data_o   = mem[cpu_addr_i];

    // Store array: cleared by reset, written by the load port or by the running core.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (load_xfer) begin
            mem[ptr] <= load_data_i;
        end else if (cpu_wr) begin
            mem[cpu_addr_i] <= cpu_data_i;
        end
    end

    // Control FSM: state, shared load/dump pointer, and registered load/dump outputs.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state        <= S_HOLD;
            ptr          <= '0;
            load_done_o  <= 1'b0;
            dump_valid_o <= 1'b0;
            dump_data_o  <= '0;
        end else begin
            load_done_o <= 1'b0;
            case (state)
                S_HOLD: begin
                    // Priority: load, then dump, then run. ptr is always 0 here.
                    if (load_start_i) begin
                        state <= S_LOAD;
                    end else if (dump_start_i) begin
                        state        <= S_DUMP;
                        dump_valid_o <= 1'b1;
                        dump_data_o  <= mem[ptr];
                    end else if (run_i) begin
                        state <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (load_valid_i) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (ptr == LAST) begin
                            state       <= S_HOLD;
                            load_done_o <= 1'b1;
                        end
                    end
                end
                S_DUMP: begin
                    // dump_valid_o is high throughout DUMP, so ready alone means a transfer.
                    if (dump_ready_i) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (ptr == LAST) begin
                            state        <= S_HOLD;
                            dump_valid_o <= 1'b0;
                        end else begin
                            dump_data_o <= mem[ptr + ADDR_W'(1)];
                        end
                    end
                end
                S_RUN: begin
                    if (cpu_stop_i) begin
                        state <= S_HOLD;
                    end
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baby_store.sv
// Testbench for baby_store: directed table, hand-written sequences and random
// traffic, all checked against a word-array model of the store.
module tb_baby_store;

    logic        clock = 1'b0;
    logic        reset_i;
    logic [4:0]  cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_rw_en_i;
    logic [31:0] cpu_data_o;
    logic        cpu_stop_i;
    logic        cpu_hold_o;
    logic        run_i;
    logic        load_start_i;
    logic        load_valid_i;
    logic [31:0] load_data_i;
    logic        load_ready_o;
    logic        load_done_o;
    logic        dump_start_i;
    logic        dump_valid_o;
    logic [31:0] dump_data_o;
    logic        dump_ready_i;

    baby_store dut (
        .clock        (clock),
        .reset_i      (reset_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_rw_en_i  (cpu_rw_en_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stop_i   (cpu_stop_i),
        .cpu_hold_o   (cpu_hold_o),
        .run_i        (run_i),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_done_o  (load_done_o),
        .dump_start_i (dump_start_i),
        .dump_valid_o (dump_valid_o),
        .dump_data_o  (dump_data_o),
        .dump_ready_i (dump_ready_i)
    );

    always #5 clock = ~clock;

    // Reference model: the store contents and whether the core is running.
    logic [31:0] model_mem [32];
    bit          running;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        rw;
        logic        stop;
        logic [31:0] exp_rd;
        logic        exp_hold;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int mode, input bit with_dump_start);
        int n;
        int cyc;
        bit v;
        load_start_i = 1'b1;
        dump_start_i = with_dump_start;
        step();
        load_start_i = 1'b0;
        dump_start_i = 1'b0;
        check("load_entry_ready", load_ready_o, 1);
        check("load_entry_no_dump", dump_valid_o, 0);
        check("load_entry_hold", cpu_hold_o, 1);
        n = 0;
        cyc = 0;
        while (n < 32 && cyc < 400) begin
            v = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            load_valid_i = v;
            load_data_i  = (mode == 0) ? 32'h1000_0000 + 32'(n) : $urandom;
            if (mode == 1) begin
                run_i        = 1'($urandom_range(0, 1));
                dump_start_i = 1'($urandom_range(0, 1));
            end
            step();
            if (v) begin
                model_mem[n] = load_data_i;
                n++;
            end
            if (n < 32) begin
                check($sformatf("load_done_early_%0d", n), load_done_o, 0);
                check($sformatf("load_ready_%0d", n), load_ready_o, 1);
            end
            cyc++;
        end
        load_valid_i = 1'b0;
        run_i        = 1'b0;
        dump_start_i = 1'b0;
        if (n < 32) check("load_timeout", n, 32);
        check("load_done_pulse", load_done_o, 1);
        check("load_ready_after", load_ready_o, 0);
        step();
        check("load_done_single", load_done_o, 0);
        check("load_hold_after", cpu_hold_o, 1);
    endtask

    task automatic do_dump(input int stall_at);
        dump_ready_i = 1'b1;
        dump_start_i = 1'b1;
        step();
        dump_start_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == stall_at) begin
                dump_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check($sformatf("dump_stall_valid_%0d", s), dump_valid_o, 1);
                    check($sformatf("dump_stall_data_%0d", s), dump_data_o, model_mem[i]);
                end
                dump_ready_i = 1'b1;
            end
            check($sformatf("dump_valid_%0d", i), dump_valid_o, 1);
            check($sformatf("dump_data_%0d", i), dump_data_o, model_mem[i]);
            step();
        end
        check("dump_end_valid", dump_valid_o, 0);
        check("dump_end_hold", cpu_hold_o, 1);
        check("dump_end_ready", load_ready_o, 0);
    endtask

    task automatic start_run();
        run_i = 1'b1;
        step();
        run_i = 1'b0;
        running = 1'b1;
        check("run_hold_low", cpu_hold_o, 0);
    endtask

    initial begin
        reset_i      = 1'b1;
        cpu_addr_i   = 5'd9;
        cpu_data_i   = '0;
        cpu_rw_en_i  = 1'b0;
        cpu_stop_i   = 1'b0;
        run_i        = 1'b0;
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        dump_start_i = 1'b0;
        dump_ready_i = 1'b0;
        running      = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;

        tbl[0] = '{5'd2, 32'h0000_0000, 1'b0, 1'b0, 32'h1000_0002, 1'b0};
        tbl[1] = '{5'd5, 32'h1234_5678, 1'b1, 1'b0, 32'h1000_0005, 1'b0};
        tbl[2] = '{5'd5, 32'h0000_0000, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
        tbl[3] = '{5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1000_0007, 1'b1};
        tbl[4] = '{5'd7, 32'h0BAD_F00D, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1};
        tbl[5] = '{5'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1000_0003, 1'b1};
        tbl[6] = '{5'd3, 32'h0000_0000, 1'b0, 1'b0, 32'h1000_0003, 1'b1};

        // Reset state
        step();
        step();
        check("rst_hold", cpu_hold_o, 1);
        check("rst_load_ready", load_ready_o, 0);
        check("rst_load_done", load_done_o, 0);
        check("rst_dump_valid", dump_valid_o, 0);
        check("rst_dump_data", dump_data_o, 0);
        check("rst_cpu_data", cpu_data_o, 0);
        #2 reset_i = 1'b0;
        step();

        // Empty store dumps as zeros
        do_dump(-1);

        // Load 0x1000_0000+n with valid on every other cycle, then read back
        do_load(0, 1'b0);
        do_dump(-1);

        // Directed core traffic
        start_run();
        for (int k = 0; k < 7; k++) begin
            cpu_addr_i  = tbl[k].addr;
            cpu_data_i  = tbl[k].wdata;
            cpu_rw_en_i = tbl[k].rw;
            cpu_stop_i  = tbl[k].stop;
            #1;
            check($sformatf("tbl_rd_%0d", k), cpu_data_o, tbl[k].exp_rd);
            step();
            if (running && tbl[k].rw) model_mem[tbl[k].addr] = tbl[k].wdata;
            if (running && tbl[k].stop) running = 1'b0;
            check($sformatf("tbl_hold_%0d", k), cpu_hold_o, 32'(tbl[k].exp_hold));
        end
        cpu_rw_en_i = 1'b0;
        cpu_stop_i  = 1'b0;
        do_dump(-1);

        // Simultaneous load/dump start picks LOAD; random load; stalled dump
        do_load(1, 1'b1);
        do_dump(4);

        // Random core traffic
        start_run();
        for (int k = 0; k < 60 && running; k++) begin
            cpu_addr_i  = 5'($urandom_range(0, 31));
            cpu_data_i  = $urandom;
            cpu_rw_en_i = 1'($urandom_range(0, 1));
            cpu_stop_i  = (k == 59) ? 1'b1 : ($urandom_range(0, 15) == 0);
            #1;
            check($sformatf("rand_rd_%0d", k), cpu_data_o, model_mem[cpu_addr_i]);
            step();
            if (cpu_rw_en_i) model_mem[cpu_addr_i] = cpu_data_i;
            if (cpu_stop_i) running = 1'b0;
            check($sformatf("rand_hold_%0d", k), cpu_hold_o, running ? 32'd0 : 32'd1);
        end
        cpu_rw_en_i = 1'b0;
        cpu_stop_i  = 1'b0;
        do_dump(-1);

        // Reset in the middle of a load at ptr = 12
        load_start_i = 1'b1;
        step();
        load_start_i = 1'b0;
        load_valid_i = 1'b1;
        for (int n = 0; n < 12; n++) begin
            load_data_i = 32'hA5A5_0000 + 32'(n);
            step();
        end
        cpu_addr_i = 5'd0;
        #2 reset_i = 1'b1;
        #1;
        check("midrst_hold", cpu_hold_o, 1);
        check("midrst_ready", load_ready_o, 0);
        check("midrst_word0", cpu_data_o, 0);
        load_valid_i = 1'b0;
        step();
        #2 reset_i = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        begin
            int dones;
            dones = 0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (load_done_o === 1'b1) dones++;
            end
            check("midrst_no_done", dones, 0);
        end
        check("midrst_state_hold", cpu_hold_o, 1);
        do_dump(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
